// File: rtl/store_buffer_pkg.sv
// Shared widths, port-arbitration encoding and address helpers for the store buffer.
// The buffer itself lives in store_buffer.sv; the forwarding search lives in sb_match.sv.
package store_buffer_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Who owns the data-memory port this cycle.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        FORCE
    } arb_t;

    // Stores and loads are word granular: byte offset bits never take part in a match.
    function automatic logic word_match(input logic [ADDR_W-3:0] a,
                                        input logic [ADDR_W-3:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-entry forwarding search: walks the FIFO from head (oldest) to newest,
// letting later matches override earlier ones.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [ADDR_W-1:0]         ent_addr [DEPTH],
    input  logic [DATA_W-1:0]         ent_data [DEPTH],
    input  logic [DEPTH-1:0]          valid,
    input  logic [$clog2(DEPTH)-1:0]  head,
    input  logic [ADDR_W-1:0]         ld_addr,
    output logic                      hit,
    output logic [DATA_W-1:0]         data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;
    logic [1:0]    unused_byte_offsets;

    always_comb begin
        hit                 = 1'b0;
        data                = '0;
        idx                 = head;
        unused_byte_offsets = ld_addr[1:0];
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            unused_byte_offsets = unused_byte_offsets ^ ent_addr[idx][1:0];
            if (valid[idx] && word_match(ent_addr[idx][ADDR_W-1:2], ld_addr[ADDR_W-1:2])) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and a single-ported data memory,
// with youngest-match load forwarding and a starvation-triggered forced drain.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic [DATA_W-1:0]          ld_data,
    output logic                       ld_stall,
    output logic [ADDR_W-1:0]          dm_address,
    output logic [DATA_W-1:0]          dm_writeData,
    output logic                       dm_memRead,
    output logic                       dm_memWrite,
    input  logic [DATA_W-1:0]          dm_readData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;
    logic [SW-1:0]     starve_q;

    logic [DEPTH-1:0]  valid;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              full;
    logic              force_due;
    logic              enq;
    logic              pop;
    arb_t              arb;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign st_ready  = !full;
    assign force_due = (starve_q == SW'(STARVE_LIMIT)) && !empty;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, PW'(PW'(i) - head_q)} < count_q);
        end
    end

    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .ent_addr (addr_q),
        .ent_data (data_q),
        .valid    (valid),
        .head     (head_q),
        .ld_addr  (ld_addr),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    // Reset is folded in so the memory port and load result go quiet the
    // moment reset rises, not only after the flops have cleared.
    always_comb begin
        arb = IDLE;
        if (reset) begin
            arb = IDLE;
        end else if (force_due) begin
            arb = FORCE;
        end else if (ld_valid) begin
            arb = LOAD;
        end else if (!empty) begin
            arb = DRAIN;
        end
    end

    always_comb begin
        dm_memRead   = 1'b0;
        dm_memWrite  = 1'b0;
        dm_address   = '0;
        dm_writeData = '0;
        ld_data      = '0;
        unique case (arb)
            LOAD: begin
                dm_memRead = 1'b1;
                dm_address = ld_addr;
                ld_data    = fwd_hit ? fwd_data : dm_readData;
            end
            DRAIN, FORCE: begin
                dm_memWrite  = 1'b1;
                dm_address   = addr_q[head_q];
                dm_writeData = data_q[head_q];
            end
            default: ;
        endcase
    end

    assign ld_stall = (arb == FORCE) && ld_valid;
    assign pop      = (arb == DRAIN) || (arb == FORCE);
    assign enq      = st_valid && st_ready && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                addr_q[tail_q] <= st_addr;
                data_q[tail_q] <= st_data;
                tail_q         <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(pop);

            if (pop) begin
                starve_q <= '0;
            end else if (full && (arb == LOAD) && (starve_q != SW'(STARVE_LIMIT))) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain timing, forwarding, starvation, wrap and async reset.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic [31:0] dm_address;
    logic [31:0] dm_writeData;
    logic        dm_memRead;
    logic        dm_memWrite;
    logic [31:0] dm_readData;
    logic [2:0]  count;
    logic        empty;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [31:0] RD = 32'h5555_0000;

    store_buffer #(
        .DEPTH        (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ready     (st_ready),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_stall     (ld_stall),
        .dm_address   (dm_address),
        .dm_writeData (dm_writeData),
        .dm_memRead   (dm_memRead),
        .dm_memWrite  (dm_memWrite),
        .dm_readData  (dm_readData),
        .count        (count),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_drain(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_wr"},   {31'b0, dm_memWrite}, 32'd1);
        chk({tag, "_addr"}, dm_address, a);
        chk({tag, "_data"}, dm_writeData, d);
    endtask

    initial begin
        // Reset held with requests active: everything must stay quiet.
        reset = 1'b1; st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hBAD;
        ld_valid = 1'b1; ld_addr = 32'h20; dm_readData = RD;
        #2;
        chk("rst_count",  {29'b0, count}, 32'd0);
        chk("rst_empty",  {31'b0, empty}, 32'd1);
        chk("rst_ready",  {31'b0, st_ready}, 32'd1);
        chk("rst_stall",  {31'b0, ld_stall}, 32'd0);
        chk("rst_lddata", ld_data, 32'd0);
        chk("rst_rd",     {31'b0, dm_memRead}, 32'd0);
        chk("rst_wr",     {31'b0, dm_memWrite}, 32'd0);
        chk("rst_addr",   dm_address, 32'd0);
        chk("rst_wdata",  dm_writeData, 32'd0);
        tick();
        chk("rst_hold_count", {29'b0, count}, 32'd0);
        reset = 1'b0; st_valid = 1'b0; ld_valid = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0;
        tick();

        // Single store drains on the following cycle.
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAAAA_0001;
        #1;
        chk("s1_nowr_same_cycle", {31'b0, dm_memWrite}, 32'd0);
        chk("s1_lddata_idle", ld_data, 32'd0);
        tick();
        st_valid = 1'b0;
        #1;
        chk("s1_count", {29'b0, count}, 32'd1);
        chk("s1_rd", {31'b0, dm_memRead}, 32'd0);
        chk_drain("s1", 32'h10, 32'hAAAA_0001);
        tick();
        #1;
        chk("s1_empty", {31'b0, empty}, 32'd1);
        chk("s1_idle_wr", {31'b0, dm_memWrite}, 32'd0);
        chk("s1_idle_addr", dm_address, 32'd0);

        // Youngest word-aligned forwarding; same-cycle store invisible to the load.
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'd1; ld_valid = 1'b1; ld_addr = 32'h100;
        #1;
        chk("fw_miss_data", ld_data, RD);
        chk("fw_miss_rd", {31'b0, dm_memRead}, 32'd1);
        chk("fw_miss_addr", dm_address, 32'h100);
        tick();
        st_data = 32'd2; ld_addr = 32'h22;
        #1;
        chk("fw_same_cycle", ld_data, 32'd1);
        tick();
        st_valid = 1'b0;
        #1;
        chk("fw_youngest", ld_data, 32'd2);
        chk("fw_rd", {31'b0, dm_memRead}, 32'd1);
        chk("fw_wr", {31'b0, dm_memWrite}, 32'd0);
        chk("fw_count", {29'b0, count}, 32'd2);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("fw_lddata_off", ld_data, 32'd0);
        chk_drain("fw_d0", 32'h20, 32'd1);
        tick();
        #1;
        chk_drain("fw_d1", 32'h20, 32'd2);
        tick();
        #1;
        chk("fw_empty", {31'b0, empty}, 32'd1);

        // Fill under continuous loads, then starvation forces a drain.
        ld_valid = 1'b1; ld_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h40 + 32'(4 * i); st_data = 32'h11 + 32'(i);
            tick();
        end
        st_addr = 32'h999; st_data = 32'hDEAD;
        #1;
        chk("sv_full_ready", {31'b0, st_ready}, 32'd0);
        chk("sv_full_count", {29'b0, count}, 32'd4);
        chk("sv_b0_stall", {31'b0, ld_stall}, 32'd0);
        chk("sv_b0_data", ld_data, RD);
        chk("sv_b0_wr", {31'b0, dm_memWrite}, 32'd0);
        tick();
        st_valid = 1'b0; ld_addr = 32'h4A;
        #1;
        chk("sv_b1_fwd", ld_data, 32'h13);
        chk("sv_b1_count", {29'b0, count}, 32'd4);
        tick();
        ld_addr = 32'h300;
        #1;
        chk("sv_b2_stall", {31'b0, ld_stall}, 32'd0);
        tick();
        #1;
        chk("sv_force_stall", {31'b0, ld_stall}, 32'd1);
        chk("sv_force_lddata", ld_data, 32'd0);
        chk("sv_force_rd", {31'b0, dm_memRead}, 32'd0);
        chk_drain("sv_force", 32'h40, 32'h11);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("sv_after_count", {29'b0, count}, 32'd3);
        chk("sv_after_ready", {31'b0, st_ready}, 32'd1);
        chk("sv_after_stall", {31'b0, ld_stall}, 32'd0);
        chk_drain("sv_d1", 32'h44, 32'h12);
        tick();
        #1;
        chk_drain("sv_d2", 32'h48, 32'h13);
        tick();
        #1;
        chk_drain("sv_d3", 32'h4C, 32'h14);
        tick();
        #1;
        chk("sv_empty", {31'b0, empty}, 32'd1);

        // Full buffer: store refused while draining, then enqueue+pop together across the wrap.
        ld_valid = 1'b1; ld_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h50 + 32'(4 * i); st_data = 32'h21 + 32'(i);
            tick();
        end
        ld_valid = 1'b0; st_addr = 32'h99C; st_data = 32'hDEAD;
        #1;
        chk("wr_full_ready", {31'b0, st_ready}, 32'd0);
        chk_drain("wr_d0", 32'h50, 32'h21);
        tick();
        #1;
        chk("wr_ready_back", {31'b0, st_ready}, 32'd1);
        chk("wr_count3", {29'b0, count}, 32'd3);
        chk_drain("wr_d1", 32'h54, 32'h22);
        tick();
        st_valid = 1'b0;
        #1;
        chk("wr_enq_pop_count", {29'b0, count}, 32'd3);
        chk_drain("wr_d2", 32'h58, 32'h23);
        tick();
        #1;
        chk_drain("wr_d3", 32'h5C, 32'h24);
        tick();
        #1;
        chk_drain("wr_d4", 32'h99C, 32'hDEAD);
        tick();
        #1;
        chk("wr_empty", {31'b0, empty}, 32'd1);

        // Asynchronous reset in the middle of a drain with two entries queued.
        ld_valid = 1'b1; ld_addr = 32'h300;
        st_valid = 1'b1; st_addr = 32'h70; st_data = 32'h31;
        tick();
        st_addr = 32'h74; st_data = 32'h32;
        tick();
        st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("ar_count", {29'b0, count}, 32'd2);
        chk_drain("ar_pre", 32'h70, 32'h31);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_wr", {31'b0, dm_memWrite}, 32'd0);
        chk("ar_addr", dm_address, 32'd0);
        chk("ar_wdata", dm_writeData, 32'd0);
        chk("ar_cnt", {29'b0, count}, 32'd0);
        chk("ar_empty", {31'b0, empty}, 32'd1);
        chk("ar_ready", {31'b0, st_ready}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("ar_post_wr", {31'b0, dm_memWrite}, 32'd0);
        chk("ar_post_count", {29'b0, count}, 32'd0);
        tick();
        #1;
        chk("ar_post2_wr", {31'b0, dm_memWrite}, 32'd0);
        chk("ar_post2_empty", {31'b0, empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries; power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 3, consecutive full-and-blocked cycles before a forced drain.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 st_valid  in  1  store request from the MEM stage.
REQ-006 st_addr  in  32  store byte address.
REQ-007 st_data  in  32  store word.
REQ-008 st_ready  out  1  buffer can accept a store this cycle.
REQ-009 ld_valid  in  1  load request from the MEM stage.
REQ-010 ld_addr  in  32  load byte address.
REQ-011 ld_data  out  32  load result: forwarded or from memory.
REQ-012 ld_stall  out  1  load not serviced this cycle; MEM stage must hold the load.
REQ-013 dm_address, dm_writeData  out  32 each  data memory port address and write word.
REQ-014 dm_memRead, dm_memWrite  out  1 each  data memory port strobes.
REQ-015 dm_readData  in  32  data memory combinational read word.
REQ-016 count  out  $clog2(DEPTH)+1  occupied entries; empty  out  1  count==0.

Function
REQ-017 The block SHALL be a circular FIFO of {addr, data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-018 st_ready SHALL be 1 iff count<DEPTH; it SHALL NOT depend combinationally on a same-cycle drain.
REQ-019 A store SHALL enqueue at the edge when st_valid&&st_ready; st_valid with st_ready=0 SHALL be ignored and the requester SHALL hold it.
REQ-020 Port arbitration, per cycle: forced drain > load > drain > idle.
REQ-021 Load cycle (ld_valid, not forced): dm_memRead=1, dm_memWrite=0, dm_address=ld_addr, ld_stall=0.
REQ-022 Drain cycle (!empty, no load serviced): dm_memWrite=1, dm_memRead=0, dm_address/dm_writeData=head entry; the head SHALL pop at that edge.
REQ-023 Idle: dm_memRead=dm_memWrite=0, dm_address=dm_writeData=0.
REQ-024 Forwarding: ld_data SHALL be the data of the youngest valid entry whose addr[31:2] equals ld_addr[31:2]; with no match it SHALL be dm_readData; it SHALL be 0 when ld_valid=0 or ld_stall=1.
REQ-025 A store enqueued in the same cycle as a load SHALL NOT be visible to that load.
REQ-026 Simultaneous enqueue and pop SHALL leave count unchanged and advance both pointers.
REQ-027 The starvation counter SHALL increment each cycle that count==DEPTH and a load blocks the drain, and SHALL clear on any pop.
REQ-028 When the counter reaches STARVE_LIMIT, the next cycle SHALL be a forced drain: ld_stall=1 if ld_valid, head popped, counter cleared.
REQ-029 Latency: a forwarded or memory load result SHALL be combinational in the request cycle; an enqueued store SHALL reach memory no earlier than the following cycle.

Reset
REQ-030 Asserting reset SHALL immediately clear pointers, count and starvation counter, and discard all entries, including any drain in progress.
REQ-031 During and after reset: count=0, empty=1, st_ready=1, ld_stall=0, ld_data=0, all dm_* outputs 0.

Structure
REQ-032 ADDR_W=32, DATA_W=32 and the arbitration-state encoding {IDLE, LOAD, DRAIN, FORCE} SHALL live in a shared package.
REQ-033 The youngest-match priority search SHALL be a sub-module sb_match (inputs: entry arrays, valid mask, head pointer, ld_addr; outputs: hit, data).

Verification
REQ-034 Store 0x10<-0xAAAA0001, no loads -> next cycle dm_memWrite=1, dm_address=0x10, dm_writeData=0xAAAA0001; empty=1 afterwards.
REQ-035 Store 0x20<-1, then 0x20<-2, then load 0x22 with ld_valid held -> ld_data=2 (youngest, word-aligned match), dm_memRead=1.
REQ-036 Fill 4 stores while loading every cycle -> st_ready=0, count=4; after 3 blocked cycles, ld_stall=1 for one cycle and count=3.
REQ-037 Fill 4 entries, then same-cycle store+drain -> store ignored, count=3, st_ready=1 next cycle; repeated fill/drain cycles wrap the pointers with data order preserved.
REQ-038 Assert reset asynchronously mid-drain with 2 entries -> outputs reach REQ-031 values before the next edge, and memory receives no further writes.
